// File: rtl/counter_pkg.sv
// Shared types for the modulo step counter: mode encoding and its decode.
package counter_pkg;

   typedef enum logic [1:0] {
      CNT_WRAP    = 2'd0,
      CNT_SAT     = 2'd1,
      CNT_ONESHOT = 2'd2,
      CNT_RSVD    = 2'd3
   } cnt_mode_e;

   // The reserved encoding behaves exactly like wrap mode.
   function automatic cnt_mode_e mode_decode(input logic [1:0] raw);
      cnt_mode_e m;
      m = cnt_mode_e'(raw);
      if (m == CNT_RSVD) begin
         m = CNT_WRAP;
      end
      return m;
   endfunction

endpackage

// File: rtl/step_next_calc.sv
// Combinational next-value calculator for the modulo step counter.
// All comparisons are done one bit wider than the counter so that
// count + step and max_val + 1 never overflow.
module step_next_calc
   import counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic [WIDTH-1:0]  count,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              up_n_down,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  next_val,
   output logic              tc,
   output logic              oor,
   output logic              cfg_err
);

   localparam int XW = WIDTH + 1;
   localparam logic [XW-1:0] ONE_X = XW'(1);

   logic [XW-1:0]    cnt_x;
   logic [XW-1:0]    max_x;
   logic [XW-1:0]    step_x;
   logic [XW-1:0]    mod_x;
   logic [XW-1:0]    sum_x;
   logic [WIDTH-1:0] diff_val;
   logic [WIDTH-1:0] wrap_up_val;
   logic [WIDTH-1:0] wrap_dn_val;
   logic             tc_up;
   logic             tc_dn;
   cnt_mode_e        mode_d;

   assign cnt_x  = {1'b0, count};
   assign max_x  = {1'b0, max_val};
   assign step_x = {{(XW-STEP_W){1'b0}}, step};
   assign mod_x  = max_x + ONE_X;
   assign sum_x  = cnt_x + step_x;

   // count > max_val - step written as count + step > max_val so a step
   // larger than max_val cannot underflow the bound.
   assign tc_up   = (sum_x > max_x);
   assign tc_dn   = (cnt_x < step_x);
   assign oor     = (cnt_x > max_x);
   assign tc      = oor | (up_n_down ? tc_up : tc_dn);
   assign cfg_err = (step_x > mod_x);

   assign diff_val    = WIDTH'(cnt_x - step_x);
   assign wrap_up_val = WIDTH'(sum_x - mod_x);
   assign wrap_dn_val = WIDTH'(cnt_x + mod_x - step_x);
   assign mode_d      = mode_decode(mode);

   // Select the value the counter takes if a step is taken this cycle.
   always_comb begin
      next_val = count;
      if (!tc) begin
         next_val = up_n_down ? sum_x[WIDTH-1:0] : diff_val;
      end else begin
         case (mode_d)
            CNT_SAT, CNT_ONESHOT: begin
               next_val = (up_n_down || oor) ? max_val : '0;
            end
            default: begin
               if (oor) begin
                  next_val = up_n_down ? '0 : max_val;
               end else begin
                  next_val = up_n_down ? wrap_up_val : wrap_dn_val;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/modulo_step_counter.sv
// Modulo step counter with runtime modulus, step size and wrap/saturate/
// one-shot modes. Holds the count, terminal pulse and done registers and
// applies the per-cycle priority: reset, load, hold, step.
module modulo_step_counter
   import counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up_n_down,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              term_pulse,
   output logic              done,
   output logic              cfg_err
);

   logic [WIDTH-1:0] count_q;
   logic             term_pulse_q;
   logic             done_q;
   logic [WIDTH-1:0] next_val;
   logic [WIDTH-1:0] load_clamped;
   logic             oor;
   logic             is_oneshot;
   logic             hold;
   logic             term_step;
   cnt_mode_e        mode_d;

   step_next_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_calc (
      .count     (count_q),
      .step      (step),
      .max_val   (max_val),
      .up_n_down (up_n_down),
      .mode      (mode),
      .next_val  (next_val),
      .tc        (tc),
      .oor       (oor),
      .cfg_err   (cfg_err)
   );

   assign mode_d       = mode_decode(mode);
   assign is_oneshot   = (mode_d == CNT_ONESHOT);
   assign load_clamped = (load_val > max_val) ? max_val : load_val;
   assign hold         = !en || (step == '0) || cfg_err || (done_q && is_oneshot);
   assign term_step    = !hold && tc;

   // Count, terminal pulse and sticky done registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= '0;
         term_pulse_q <= 1'b0;
         done_q       <= 1'b0;
      end else if (load) begin
         count_q      <= load_clamped;
         term_pulse_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         if (!hold) begin
            count_q <= next_val;
         end
         term_pulse_q <= term_step;
         done_q       <= is_oneshot && (done_q || term_step);
      end
   end

   assign count      = count_q;
   assign term_pulse = term_pulse_q;
   assign done       = done_q;

endmodule
